// File: rtl/util_stepdw_pkg.sv
// Shared definitions for the 128b->32b step-down transfer sequencer.
package util_stepdw_pkg;

    localparam int unsigned RATIO = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/util_skid2.sv
// Two-entry valid/ready holding buffer; head entry drives the registered output.
module util_skid2 #(
    parameter int unsigned W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] head_q, tail_q;
    logic [1:0]   occ_q;
    logic         do_pop, do_push;

    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

    assign dout_o  = head_q;
    assign valid_o = (occ_q != 2'd0);
    assign occ_o   = occ_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else if (do_push && do_pop) begin
            if (occ_q == 2'd1) begin
                head_q <= din_i;
            end else begin
                head_q <= tail_q;
                tail_q <= din_i;
            end
        end else if (do_pop) begin
            head_q <= tail_q;
            occ_q  <= occ_q - 2'd1;
        end else if (do_push) begin
            if (occ_q == 2'd0) begin
                head_q <= din_i;
            end else begin
                tail_q <= din_i;
            end
            occ_q <= occ_q + 2'd1;
        end
    end

endmodule

// File: rtl/util_stepdw_ctrl.sv
// Sequences one word-count command through the step-down FIFO: admits whole
// upstream beats, drains them as 32b words, trims the tail and flags the last word.
module util_stepdw_ctrl
    import util_stepdw_pkg::*;
#(
    parameter int unsigned DW_IN  = 128,
    parameter int unsigned DW_OUT = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [CNT_W-1:0]  cmd_words_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              fifo_wren_o,
    output logic              fifo_rden_o,
    input  logic              fifo_full_i,
    input  logic              fifo_empty_i,
    input  logic [DW_OUT-1:0] fifo_dout_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DW_OUT-1:0] m_data_o,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned TW = CNT_W + 2;

    if (DW_IN != DW_OUT * RATIO) begin : g_bad_ratio
        $error("util_stepdw_ctrl: DW_IN must equal DW_OUT*RATIO");
    end

    state_e           state_q;
    logic [CNT_W-1:0] n_q, beats_q, beats_in_q;
    logic [TW-1:0]    total_q, words_rd_q;
    logic             inflight_q, keep_q, last_q;
    logic             cmd_ready_q, busy_q, done_q;

    logic             run, pop, xfer_end;
    logic [1:0]       occ;
    logic [2:0]       occ_eff;
    logic [CNT_W-1:0] cmd_beats;

    assign run       = (state_q == ST_RUN);
    assign cmd_beats = CNT_W'(ceil_div(32'(cmd_words_i), RATIO));

    assign s_ready_o   = run && !fifo_full_i && (beats_in_q < beats_q);
    assign fifo_wren_o = s_valid_i && s_ready_o;

    // Counting this cycle's pop lets a free-flowing sink take one word per cycle.
    assign pop     = m_valid_o && m_ready_i;
    assign occ_eff = 3'(occ) + 3'(inflight_q) - 3'(pop);
    assign fifo_rden_o = run && !fifo_empty_i && (words_rd_q < total_q) && (occ_eff < 3'd2);

    assign xfer_end = (beats_in_q == beats_q) && (words_rd_q == total_q)
                      && !inflight_q && (occ == 2'd0);

    util_skid2 #(
        .W (DW_OUT + 1)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_q && keep_q),
        .din_i   ({last_q, fifo_dout_i}),
        .pop_i   (pop),
        .dout_o  ({m_last_o, m_data_o}),
        .valid_o (m_valid_o),
        .occ_o   (occ)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            beats_q     <= '0;
            beats_in_q  <= '0;
            total_q     <= '0;
            words_rd_q  <= '0;
            inflight_q  <= 1'b0;
            keep_q      <= 1'b0;
            last_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= fifo_rden_o;
            done_q     <= 1'b0;
            // Tag each read with its word index so tail words are dropped on arrival.
            if (fifo_rden_o) begin
                keep_q     <= words_rd_q < TW'(n_q);
                last_q     <= (words_rd_q + TW'(1)) == TW'(n_q);
                words_rd_q <= words_rd_q + TW'(1);
            end
            if (fifo_wren_o) begin
                beats_in_q <= beats_in_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        n_q         <= cmd_words_i;
                        beats_q     <= cmd_beats;
                        total_q     <= TW'(cmd_beats) * TW'(RATIO);
                        beats_in_q  <= '0;
                        words_rd_q  <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_words_i == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer_end) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_util_stepdw_ctrl.sv
// Randomized bench for util_stepdw_ctrl with a word-queue FIFO and delivery model.
module tb_util_stepdw_ctrl;

    localparam int unsigned DEPTH_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_words = '0;
    logic        s_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout = '0;
    logic        m_ready = 1'b0;
    logic        cmd_ready, s_ready, fifo_wren, fifo_rden, m_valid, m_last, busy, done;
    logic [31:0] m_data;

    util_stepdw_ctrl #(.DW_IN(128), .DW_OUT(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_words_i(cmd_words),
        .s_valid_i(s_valid), .s_ready_o(s_ready),
        .fifo_wren_o(fifo_wren), .fifo_rden_o(fifo_rden),
        .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty), .fifo_dout_i(fifo_dout),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model state
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int  m_n = 0, m_pushed = 0, m_deliv = 0, m_wren = 0, m_rden = 0;
    int  done_cnt = 0, last_idx = -1, cyc = 0, first_rden_cyc = -1;
    bit  m_active = 0, busy_exp = 0, got_first_v = 0, prev_stall = 0;
    logic [32:0] prev_out = '0;
    int  mready_mode = 0, svalid_mode = 0, ff_left = 0;
    logic cap_done, cap_cmd_ready, cap_mvalid, cap_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare outputs, advance the edge, update the FIFO/delivery model, drive inputs.
    task automatic step();
        logic wren_s, rden_s, acc, rst_s, done_s;
        int   wlim, rlim;
        logic [31:0] w;
        #2;
        wren_s = fifo_wren; rden_s = fifo_rden; done_s = done; rst_s = rst;
        cap_done = done; cap_cmd_ready = cmd_ready; cap_mvalid = m_valid; cap_busy = busy;
        wlim = m_active ? (m_n + 3) / 4 : 0;
        rlim = 4 * wlim;
        check("cmd_ready_vs_busy", cmd_ready, !busy);
        check("busy", busy, busy_exp);
        if (!busy_exp) check("done_while_idle", done, 0);
        check("wren_eq_handshake", fifo_wren, s_valid & s_ready);
        if (fifo_wren) begin
            check("wren_while_full", fifo_full, 0);
            check("wren_beyond_beats", m_wren < wlim, 1);
        end
        if (fifo_rden) begin
            check("rden_while_empty", fifo_empty, 0);
            check("rden_beyond_words", m_rden < rlim, 1);
        end
        if (prev_stall) begin
            check("stall_valid_held", m_valid, 1);
            check("stall_data_held", {m_last, m_data}, prev_out);
        end
        if (m_valid) begin
            check("valid_only_for_live_words", m_deliv < m_n, 1);
            if (!got_first_v) begin
                check("first_word_latency", (first_rden_cyc >= 0) && (cyc - first_rden_cyc >= 2), 1);
                got_first_v = 1;
            end
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("word_available", 0, 1);
            end else begin
                check("m_data", m_data, exp_q.pop_front());
                check("m_last", m_last, m_deliv == m_n - 1);
                if (m_last) last_idx = m_deliv;
                m_deliv++;
            end
        end
        if (done_s) begin
            check("done_words", m_deliv, m_n);
            check("done_wren", m_wren, (m_n + 3) / 4);
            check("done_rden", m_rden, 4 * ((m_n + 3) / 4));
            done_cnt++;
            m_active = 0;
        end
        acc = cmd_valid & cmd_ready;
        prev_stall = m_valid & !m_ready;
        prev_out = {m_last, m_data};

        @(posedge clk);
        #1;
        if (wren_s) begin
            m_wren++;
            for (int k = 0; k < 4; k++) begin
                w = $urandom;
                fifo_q.push_back(w);
                if (m_pushed < m_n) exp_q.push_back(w);
                m_pushed++;
            end
        end
        if (rden_s) begin
            m_rden++;
            if (first_rden_cyc < 0) first_rden_cyc = cyc;
            if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        end
        if (done_s) busy_exp = 0;
        if (acc) begin
            m_n = int'(cmd_words); m_pushed = 0; m_deliv = 0; m_wren = 0; m_rden = 0;
            m_active = (cmd_words != 0); busy_exp = 1; exp_q.delete();
            got_first_v = 0; first_rden_cyc = -1; last_idx = -1;
        end
        if (rst_s) begin
            fifo_q.delete(); exp_q.delete();
            m_active = 0; busy_exp = 0; prev_stall = 0; m_n = 0;
        end
        cyc++;
        if (ff_left > 0) ff_left--;
        fifo_empty = (fifo_q.size() == 0);
        fifo_full  = (ff_left > 0) || (fifo_q.size() > DEPTH_W - 4);
        s_valid    = (svalid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        case (mready_mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_xfer(input int n, input int mr, input int sv, input int full_cyc,
                            input int abort_at, input bit poke);
        int cycles, dc0;
        mready_mode = mr; svalid_mode = sv;
        if (mr == 1) m_ready = 1'b1;
        dc0 = done_cnt;
        cmd_words = 16'(n); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        ff_left = full_cyc;
        if (full_cyc > 0) fifo_full = 1'b1;
        cycles = 0;
        while (done_cnt == dc0 && cycles < 4000) begin
            if (abort_at > 0 && m_deliv >= abort_at) begin
                rst = 1'b1; step(); rst = 1'b0;
                step();
                check("rst_m_valid", cap_mvalid, 0);
                check("rst_busy", cap_busy, 0);
                check("rst_cmd_ready", cap_cmd_ready, 1);
                return;
            end
            cmd_valid = poke && cycles >= 3 && cycles < 6;
            cmd_words = 16'(n + 9);
            step();
            cycles++;
        end
        cmd_valid = 1'b0;
        if (done_cnt == dc0) check("transfer_timeout", 0, 1);
        if (n == 0) check("zero_done_next_cycle", cycles, 1);
        step();
        check("ready_back_after_done", cap_cmd_ready, 1);
        step();
        check("done_once", done_cnt - dc0, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step();
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_done", done, 0);
        check("reset_s_ready", s_ready, 0);
        check("reset_rden", fifo_rden, 0);
        rst = 1'b0;
        step();

        run_xfer(16, 0, 0, 0, 0, 0);
        check("t1_wren", m_wren, 4);
        check("t1_rden", m_rden, 16);
        check("t1_words", m_deliv, 16);
        check("t1_last_idx", last_idx, 15);

        run_xfer(6, 0, 0, 0, 0, 0);
        check("t2_wren", m_wren, 2);
        check("t2_rden", m_rden, 8);
        check("t2_words", m_deliv, 6);
        check("t2_last_idx", last_idx, 5);

        run_xfer(0, 0, 0, 0, 0, 0);
        check("t3_wren", m_wren, 0);
        check("t3_rden", m_rden, 0);

        run_xfer(64, 1, 0, 10, 0, 0);
        check("t4_words", m_deliv, 64);
        check("t4_last_idx", last_idx, 63);

        run_xfer(40, 0, 0, 0, 7, 0);
        run_xfer(4, 0, 0, 0, 0, 0);
        check("t5_words", m_deliv, 4);
        check("t5_wren", m_wren, 1);

        run_xfer(20, 2, 1, 0, 0, 1);
        check("t6_words", m_deliv, 20);
        check("t6_wren", m_wren, 5);

        for (int i = 0; i < 10; i++) begin
            run_xfer($urandom_range(1, 45), $urandom_range(2, 3), $urandom_range(0, 1),
                     $urandom_range(0, 1) * $urandom_range(1, 8), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
